alu: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/fp8_norm_pack.sv | 29 ++
 rtl/alu.sv | 82 ++++++++
 tb/tb_alu.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared FP8 E4M3 format constants, opcodes and FSM states for the alu
package alu_pkg;
    localparam int EXP_W = 4;
    localparam int MAN_W = 3;
    localparam int BIAS  = 7;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;

    // magnitude used for overflow: exponent 15, mantissa 6 (448)
    localparam logic [6:0] SAT = 7'b1111110;

    typedef enum logic [1:0] {IDLE, EXEC, NORM, DONE} state_t;
endpackage

// File: rtl/fp8_norm_pack.sv
// fp8_norm_pack: leading-one normalise, truncate, flush-to-zero and saturate into FP8 E4M3
//   sign_i  result sign
//   exp_i   signed biased exponent, valid when the leading one sits at sig_i[6]
//   sig_i   significand with 6 fractional bits (leading one at bit 6 or 7, or lower after cancellation)
//   fp_o    packed FP8 result
module fp8_norm_pack
    import alu_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [6:0] exp_i,
    input  logic        [7:0] sig_i,
    output logic        [7:0] fp_o
);
    logic [2:0] lead;
    logic signed [7:0] exp_n;
    logic [MAN_W-1:0] man;

    always_comb begin
        lead = '0;
        for (int i = 0; i < 8; i++)
            if (sig_i[i]) lead = 3'(i);
        // move the leading one to bit 7; the next three bits are the truncated mantissa
        man = 3'((sig_i << (3'd7 - lead)) >> 4);
        exp_n = {exp_i[6], exp_i} + 8'(lead) - 8'sd6;
        fp_o = (sig_i == '0 || exp_n <= 8'sd0) ? 8'h00 :
               (exp_n > 8'sd15 || (exp_n == 8'sd15 && man == 3'b111)) ? {sign_i, SAT} :
               {sign_i, exp_n[EXP_W-1:0], man};
    end
endmodule

// File: rtl/alu.sv
// alu: multi-cycle FP8 E4M3 add/multiply, one operation launched per reset release
//   a, b             FP8 operands, sampled on the first edge after reset falls
//   alu_ctrl         opcode (ADD / MUL, others give +0)
//   clock, reset     rising-edge clock, async active-high reset
//   y                packed FP8 result
//   is_output_valid  sticky until the next reset
module alu
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] alu_ctrl,
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] y,
    output logic       is_output_valid
);
    state_t state_q, state_d;
    logic sa_q, sb_q, rs_q, rs_d, valid_q, a_big, add_s;
    logic [EXP_W-1:0] ea_q, eb_q, big_e, diff;
    logic [MAN_W:0] ma_q, mb_q;
    logic signed [6:0] re_q, re_d;
    logic [7:0] rsig_q, rsig_d, sum, prod, y_q, y_d;
    logic [6:0] big_sig, sml_sig;
    logic [3:0] op_q;

    always_comb begin
        state_d = state_q == IDLE ? EXEC : state_q == EXEC ? NORM : DONE;
        // larger magnitude operand decides the sign and the reference exponent
        a_big = (ea_q > eb_q) || (ea_q == eb_q && ma_q >= mb_q);
        big_e = a_big ? ea_q : eb_q;
        diff = a_big ? ea_q - eb_q : eb_q - ea_q;
        big_sig = {a_big ? ma_q : mb_q, 3'b000};
        // a 7-bit value shifted by 7 or more is already zero
        sml_sig = {a_big ? mb_q : ma_q, 3'b000} >> diff;
        sum = sa_q == sb_q ? {1'b0, big_sig} + {1'b0, sml_sig} : {1'b0, big_sig} - {1'b0, sml_sig};
        add_s = a_big ? sa_q : sb_q;
        prod = {4'b0000, ma_q} * {4'b0000, mb_q};
        rs_d = op_q == OP_ADD ? add_s : op_q == OP_MUL ? sa_q ^ sb_q : 1'b0;
        re_d = op_q == OP_ADD ? {3'b000, big_e} :
               op_q == OP_MUL ? {3'b000, ea_q} + {3'b000, eb_q} - 7'(BIAS) : 7'sd0;
        rsig_d = op_q == OP_ADD ? sum : op_q == OP_MUL ? prod : 8'h00;
    end

    fp8_norm_pack u_norm (
        .sign_i (rs_q),
        .exp_i  (re_q),
        .sig_i  (rsig_q),
        .fp_o   (y_d)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) state_q <= IDLE;
        else state_q <= state_d;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            {sa_q, sb_q, ea_q, eb_q, ma_q, mb_q, op_q} <= '0;
            {rs_q, re_q, rsig_q} <= '0;
            y_q <= 8'h00;
            valid_q <= 1'b0;
        end else if (state_q == IDLE) begin
            sa_q <= a[7];
            sb_q <= b[7];
            ea_q <= a[6:3];
            eb_q <= b[6:3];
            // zero exponent flushes the operand, mantissa ignored
            ma_q <= a[6:3] == '0 ? '0 : {1'b1, a[2:0]};
            mb_q <= b[6:3] == '0 ? '0 : {1'b1, b[2:0]};
            op_q <= alu_ctrl;
        end else if (state_q == EXEC) begin
            rs_q <= rs_d;
            re_q <= re_d;
            rsig_q <= rsig_d;
        end else if (state_q == NORM) begin
            y_q <= y_d;
            valid_q <= 1'b1;
        end

    assign y = y_q;
    assign is_output_valid = valid_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for the FP8 alu with directed vectors
module tb_alu;
    logic [7:0] a, b, y;
    logic [3:0] alu_ctrl;
    logic clock, reset, is_output_valid;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[20] = '{
        '{8'h40, 8'h40, 4'b0001, 8'h48},
        '{8'h28, 8'h10, 4'b0001, 8'h29},
        '{8'h50, 8'h10, 4'b0001, 8'h50},
        '{8'h50, 8'hD0, 4'b0001, 8'h00},
        '{8'h41, 8'hC0, 4'b0001, 8'h28},
        '{8'h48, 8'hD0, 4'b0001, 8'hC8},
        '{8'hC8, 8'hD0, 4'b0001, 8'hD4},
        '{8'h00, 8'h38, 4'b0001, 8'h38},
        '{8'h77, 8'h77, 4'b0001, 8'h7E},
        '{8'h40, 8'h40, 4'b0010, 8'h48},
        '{8'h38, 8'h38, 4'b0010, 8'h38},
        '{8'h38, 8'hB8, 4'b0010, 8'hB8},
        '{8'h40, 8'h39, 4'b0010, 8'h41},
        '{8'hAC, 8'hC0, 4'b0010, 8'h34},
        '{8'h00, 8'h00, 4'b0010, 8'h00},
        '{8'h80, 8'h38, 4'b0010, 8'h00},
        '{8'h77, 8'h77, 4'b0010, 8'h7E},
        '{8'h08, 8'h08, 4'b0010, 8'h00},
        '{8'h40, 8'h40, 4'b0000, 8'h00},
        '{8'h40, 8'h40, 4'b1111, 8'h00}
    };

    logic [7:0] sb[$];
    int checks = 0, passed = 0;
    logic prev_v = 1'b0;

    alu dut (
        .a               (a),
        .b               (b),
        .alu_ctrl        (alu_ctrl),
        .clock           (clock),
        .reset           (reset),
        .y               (y),
        .is_output_valid (is_output_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic ok, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: y=%h valid=%b, required y=%h", name, got, is_output_valid, want);
    endtask

    // monitor: compare each newly presented result against the oldest expectation
    always @(negedge clock) begin
        if (is_output_valid && !prev_v) begin
            if (sb.size() == 0) check("unexpected_valid", 1'b0, y, 8'h00);
            else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("result", y === e, y, e);
            end
        end
        prev_v = is_output_valid;
    end

    task automatic run(input vec_t v);
        int n;
        @(posedge clock);
        #3;
        reset = 1'b1;
        a = v.a;
        b = v.b;
        alu_ctrl = v.op;
        #2;
        check("async_reset_clear", is_output_valid === 1'b0 && y === 8'h00, y, 8'h00);
        @(posedge clock);
        #3;
        sb.push_back(v.y);
        reset = 1'b0;
        n = 0;
        do begin
            @(posedge clock);
            n++;
            #1;
            if (n == 1) begin
                a = ~v.a;
                b = ~v.b;
                alu_ctrl = ~v.op;
            end
        end while (!is_output_valid && n < 6);
        check("latency", is_output_valid === 1'b1 && n <= 4, y, v.y);
        repeat (3) begin
            @(posedge clock);
            #1;
            check("hold", is_output_valid === 1'b1 && y === v.y, y, v.y);
        end
    endtask

    initial begin
        reset = 1'b1;
        a = 8'h00;
        b = 8'h00;
        alu_ctrl = 4'b0000;
        #12;
        check("reset_state", is_output_valid === 1'b0 && y === 8'h00, y, 8'h00);
        // abort an operation in flight; its operands must not leak into the next run
        @(posedge clock);
        #3;
        a = 8'h77;
        b = 8'h77;
        alu_ctrl = 4'b0010;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_clear", is_output_valid === 1'b0 && y === 8'h00, y, 8'h00);
        foreach (vecs[i]) run(vecs[i]);
        @(negedge clock);
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
